// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin share of the cmd_proc channel between
// the UART wrapper and the tour sequencer, with a stall watchdog.
module cmd_arbiter #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_uart,
  input  logic        cmd_rdy_uart,
  output logic        clr_uart,
  input  logic [15:0] cmd_tour,
  input  logic        cmd_rdy_tour,
  output logic        clr_tour,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        ack_uart,
  output logic        ack_tour,
  output logic        grant_tour,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clr_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

  state_t          state_q, state_d;
  logic [15:0]     hold_d;
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;
  logic            last_q, last_d;
  logic            pick_tour;
  logic            grant_d, cmd_rdy_d, busy_d, err_d;
  logic            clr_uart_d, clr_tour_d;
  logic            ack_uart_d, ack_tour_d;

  assign wd_inc    = (&wd_q) ? wd_q : wd_q + 1'b1;
  // contested request goes to whoever did not own the channel last
  assign pick_tour = cmd_rdy_tour & (~cmd_rdy_uart | ~last_q);

  always_comb begin
    state_d    = state_q;
    hold_d     = cmd;
    wd_d       = wd_q;
    last_d     = last_q;
    grant_d    = grant_tour;
    cmd_rdy_d  = cmd_rdy;
    clr_uart_d = 1'b0;
    clr_tour_d = 1'b0;
    ack_uart_d = 1'b0;
    ack_tour_d = 1'b0;
    err_d      = timeout_err & ~clr_err;
    unique case (state_q)
      IDLE: begin
        if (cmd_rdy_uart | cmd_rdy_tour) begin
          state_d    = ISSUE;
          hold_d     = pick_tour ? cmd_tour : cmd_uart;
          last_d     = pick_tour;
          grant_d    = pick_tour;
          wd_d       = '0;
          cmd_rdy_d  = 1'b1;
          clr_tour_d = pick_tour;
          clr_uart_d = ~pick_tour;
        end
      end
      ISSUE: begin
        wd_d = wd_inc;
        if (clr_cmd_rdy & send_resp) begin
          state_d    = IDLE;
          cmd_rdy_d  = 1'b0;
          ack_tour_d = grant_tour;
          ack_uart_d = ~grant_tour;
        end else if (wd_inc >= TO_LIM) begin
          state_d   = IDLE;
          cmd_rdy_d = 1'b0;
          err_d     = 1'b1;
        end else if (clr_cmd_rdy) begin
          state_d   = WAIT_RESP;
          cmd_rdy_d = 1'b0;
        end
      end
      WAIT_RESP: begin
        wd_d = wd_inc;
        if (send_resp) begin
          state_d    = IDLE;
          ack_tour_d = grant_tour;
          ack_uart_d = ~grant_tour;
        end else if (wd_inc >= TO_LIM) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cmd_rdy_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd         <= 16'h0000;
      wd_q        <= '0;
      last_q      <= 1'b1;
      grant_tour  <= 1'b0;
      cmd_rdy     <= 1'b0;
      busy        <= 1'b0;
      clr_uart    <= 1'b0;
      clr_tour    <= 1'b0;
      ack_uart    <= 1'b0;
      ack_tour    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd         <= hold_d;
      wd_q        <= wd_d;
      last_q      <= last_d;
      grant_tour  <= grant_d;
      cmd_rdy     <= cmd_rdy_d;
      busy        <= busy_d;
      clr_uart    <= clr_uart_d;
      clr_tour    <= clr_tour_d;
      ack_uart    <= ack_uart_d;
      ack_tour    <= ack_tour_d;
      timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: directed checks of grant order, handshakes,
// watchdog abort and async reset of cmd_arbiter.
module tb_cmd_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cmd_uart, cmd_tour, cmd;
  logic        cmd_rdy_uart, cmd_rdy_tour;
  logic        clr_uart, clr_tour;
  logic        cmd_rdy, clr_cmd_rdy, send_resp;
  logic        ack_uart, ack_tour;
  logic        grant_tour, busy, timeout_err, clr_err;

  int total = 0;
  int bad   = 0;

  cmd_arbiter #(
    .TIMEOUT_CYC(20),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_uart(cmd_uart),
    .cmd_rdy_uart(cmd_rdy_uart),
    .clr_uart(clr_uart),
    .cmd_tour(cmd_tour),
    .cmd_rdy_tour(cmd_rdy_tour),
    .clr_tour(clr_tour),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp),
    .ack_uart(ack_uart),
    .ack_tour(ack_tour),
    .grant_tour(grant_tour),
    .busy(busy),
    .timeout_err(timeout_err),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // grant edge is the next posedge; returns in the ack cycle
  task automatic xact(input logic t,
                      input logic [15:0] c,
                      input logic keep);
    tick();
    chk("clr_uart", 32'(clr_uart), 32'(!t));
    chk("clr_tour", 32'(clr_tour), 32'(t));
    chk("cmd", 32'(cmd), 32'(c));
    chk("cmd_rdy", 32'(cmd_rdy), 1);
    chk("grant", 32'(grant_tour), 32'(t));
    chk("busy", 32'(busy), 1);
    if (!keep) begin
      if (t) cmd_rdy_tour = 1'b0;
      else   cmd_rdy_uart = 1'b0;
    end
    tick();
    chk("clr_pulse", 32'({clr_uart, clr_tour}), 0);
    chk("cmd_hold", 32'(cmd), 32'(c));
    chk("cmd_rdy_hold", 32'(cmd_rdy), 1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_drop", 32'(cmd_rdy), 0);
    chk("busy_wait", 32'(busy), 1);
    chk("cmd_wait", 32'(cmd), 32'(c));
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("ack_uart", 32'(ack_uart), 32'(!t));
    chk("ack_tour", 32'(ack_tour), 32'(t));
    chk("busy_done", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_uart = '0;
    cmd_tour = '0;
    cmd_rdy_uart = 1'b0;
    cmd_rdy_tour = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    clr_err = 1'b0;
    tick();
    tick();
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_outs", 32'({cmd_rdy, busy, grant_tour, timeout_err,
                         clr_uart, clr_tour, ack_uart, ack_tour}), 0);
    rst = 1'b0;
    tick();

    // single UART command
    cmd_uart = 16'h4001;
    cmd_rdy_uart = 1'b1;
    xact(1'b0, 16'h4001, 1'b0);
    tick();
    chk("ack_pulse", 32'({ack_uart, ack_tour}), 0);

    // contested requests alternate, UART first after reset
    do_reset();
    cmd_uart = 16'h2000;
    cmd_tour = 16'h5BF2;
    cmd_rdy_uart = 1'b1;
    cmd_rdy_tour = 1'b1;
    xact(1'b0, 16'h2000, 1'b0);
    xact(1'b1, 16'h5BF2, 1'b0);
    cmd_rdy_uart = 1'b1;
    cmd_rdy_tour = 1'b1;
    xact(1'b0, 16'h2000, 1'b0);
    xact(1'b1, 16'h5BF2, 1'b0);
    tick();
    chk("idle_after_alt", 32'(busy), 0);

    // tour rdy held for three commands
    cmd_tour = 16'h4002;
    cmd_rdy_tour = 1'b1;
    xact(1'b1, 16'h4002, 1'b1);
    cmd_tour = 16'h53F1;
    xact(1'b1, 16'h53F1, 1'b1);
    cmd_tour = 16'h47F2;
    xact(1'b1, 16'h47F2, 1'b1);
    cmd_rdy_tour = 1'b0;
    tick();
    chk("tour_end_ack", 32'({ack_uart, ack_tour}), 0);
    chk("tour_end_busy", 32'(busy), 0);

    // consume and respond in the same ISSUE cycle
    cmd_uart = 16'h1234;
    cmd_rdy_uart = 1'b1;
    tick();
    chk("same_clr", 32'(clr_uart), 1);
    cmd_rdy_uart = 1'b0;
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    chk("same_ack", 32'({ack_uart, ack_tour}), 32'b10);
    chk("same_idle", 32'({cmd_rdy, busy}), 0);
    tick();
    chk("same_no_dup", 32'({ack_uart, clr_uart, cmd_rdy, busy}), 0);

    // watchdog: cmd_rdy high for exactly 20 cycles
    cmd_tour = 16'h0ABC;
    cmd_rdy_tour = 1'b1;
    tick();
    chk("to_issue", 32'(cmd_rdy), 1);
    cmd_rdy_tour = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    chk("to_c19_err", 32'(timeout_err), 0);
    tick();
    chk("to_c20_rdy", 32'(cmd_rdy), 1);
    tick();
    chk("to_c21_rdy", 32'(cmd_rdy), 0);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_noack", 32'({ack_uart, ack_tour}), 0);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("late_resp", 32'({ack_uart, ack_tour, busy}), 0);
    chk("err_sticky", 32'(timeout_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err_clr", 32'(timeout_err), 0);

    // async reset during WAIT_RESP
    cmd_uart = 16'h3333;
    cmd_rdy_uart = 1'b1;
    tick();
    cmd_rdy_uart = 1'b0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst", 32'({cmd_rdy, busy, ack_uart, ack_tour}), 0);
    tick();
    rst = 1'b0;
    cmd_uart = 16'h2000;
    cmd_tour = 16'h5BF2;
    cmd_rdy_uart = 1'b1;
    cmd_rdy_tour = 1'b1;
    xact(1'b0, 16'h2000, 1'b0);
    xact(1'b1, 16'h5BF2, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Shares the single cmd_proc command/response channel between two command sources: the UART wrapper (host commands) and the tour command sequencer (autonomous knight moves).
- Captures one command at a time from a source and presents it to cmd_proc with a cmd_rdy/clr_cmd_rdy handshake.
- Waits for send_resp, then returns a one-cycle acknowledge to the owning source.
- Round-robin arbitration when both sources are pending; a watchdog aborts a transaction that stalls.

Parameters:
TIMEOUT_CYC, 50_000_000, cycles allowed from issue to send_resp before abort (1 s at 50 MHz); bench overrides to a small value.
TO_W, 26, width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset, asynchronous, active-high
cmd_uart  in  16  command from UART wrapper
cmd_rdy_uart  in  1  UART command pending (level, held until clr_uart)
clr_uart  out  1  one-cycle pulse: UART command captured
cmd_tour  in  16  command from tour sequencer
cmd_rdy_tour  in  1  tour command pending (level, held until clr_tour)
clr_tour  out  1  one-cycle pulse: tour command captured
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc consumed cmd
send_resp  in  1  cmd_proc finished executing cmd
ack_uart  out  1  one-cycle pulse: UART command completed
ack_tour  out  1  one-cycle pulse: tour command completed
grant_tour  out  1  current/last owner (1 = tour, 0 = UART)
busy  out  1  transaction in progress (state != IDLE)
timeout_err  out  1  sticky watchdog abort flag
clr_err  in  1  clears timeout_err

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; cmd=16'h0000; hold register=0; watchdog=0; last_grant internally=tour, so the first contested grant goes to UART.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE, neither rdy: remain.
- IDLE, exactly one rdy: grant that source.
- IDLE, both rdy: grant the source not equal to last_grant.
- On grant (edge ending cycle N), at cycle N+1:
  - state=ISSUE; hold register=granted source's cmd; cmd=hold register.
  - cmd_rdy=1; clr_<src>=1 for exactly one cycle.
  - grant_tour and last_grant updated; watchdog cleared.
- Source rdy still high in cycle N+1 is ignored, because arbitration happens only in IDLE.
- ISSUE:
  - cmd_rdy held 1 and cmd stable until clr_cmd_rdy; then cmd_rdy=0 next cycle and go to WAIT_RESP.
  - clr_cmd_rdy together with send_resp in the same cycle: treat as complete, go to IDLE and issue ack.
  - send_resp without clr_cmd_rdy: ignored.
- WAIT_RESP:
  - cmd held stable and cmd_rdy=0.
  - On send_resp: go to IDLE; ack_<owner>=1 for one cycle in the following cycle.
- A new grant may occur in the same IDLE cycle in which ack is high; minimum IDLE dwell is 1 cycle.
- Watchdog:
  - Increments every cycle in ISSUE and WAIT_RESP; saturates.
  - On reaching TIMEOUT_CYC: next cycle cmd_rdy=0, state=IDLE, timeout_err=1, no ack issued.
  - A subsequent send_resp while IDLE is ignored.
- timeout_err stays set until clr_err; if set and clear occur in the same cycle, set wins.
- busy=1 in ISSUE and WAIT_RESP.
- grant_tour holds its value through IDLE.
- Async reset mid-transaction: returns to IDLE immediately, cmd_rdy drops, no ack or clr pulse generated.
- cmd_proc is never offered a second command before send_resp or timeout of the first.

Test Plan:
- Reset, then cmd_rdy_uart=1 with cmd_uart=16'h4001 -> clr_uart pulse 1 cycle, then cmd=16'h4001, cmd_rdy=1, grant_tour=0; clr_cmd_rdy -> cmd_rdy=0; send_resp -> ack_uart 1-cycle pulse, busy=0.
- Both rdy asserted at the same time with cmd_uart=16'h2000 and cmd_tour=16'h5BF2 -> UART served first; tour (16'h5BF2) served immediately after the UART ack; ack_tour follows; repeat both -> UART again (alternation verified over 4 transactions).
- Tour rdy held continuously for 3 commands (16'h4002, 16'h53F1, 16'h47F2) with UART idle -> served in order; each gets exactly one clr_tour and one ack_tour; no ack_uart.
- clr_cmd_rdy and send_resp asserted in the same cycle during ISSUE -> single ack, return to IDLE, no duplicate issue.
- TIMEOUT_CYC=20, never assert send_resp -> cmd_rdy drops 20 cycles after issue, timeout_err=1, no ack; a late send_resp is ignored; clr_err -> timeout_err=0.
- Assert rst during WAIT_RESP -> cmd_rdy, busy, ack_* all 0 immediately; after release, a fresh contested request grants UART first.
